// File: rtl/board_gpio_ctrl.sv
// board_gpio_ctrl
// Board GPIO block: debounced switch inputs with sticky change flags and a
// level interrupt, plus an LED register driving the board LEDs, all reachable
// over a simple single-cycle request/ack host bus.
//
// Ports:
//   clk_i        sole clock, everything on the rising edge
//   rst_i        synchronous active-high reset
//   sw_i         raw asynchronous board switches (SW_WIDTH bits)
//   led_o        registered LED drive (LED_WIDTH bits)
//   bus_req_i    host request, sampled every cycle
//   bus_we_i     1 = write, 0 = read
//   bus_addr_i   byte address, register selected by bits [3:2]
//   bus_wdata_i  write data
//   bus_ack_o    one-cycle acknowledge, exactly one cycle after the request
//   bus_rdata_o  read data, valid only while bus_ack_o is high (else 0)
//   irq_o        level interrupt: irq_en & any edge flag, registered
//
// Register map (bus_addr_i[3:2]):
//   0 SW   read-only debounced switch state, zero-extended
//   1 LED  read/write LED register
//   2 EDGE sticky switch-change flags, write 1 to clear
//   3 CTRL [7:0] PWM duty, [8] irq_en
//
// Optional feature macro: BOARD_GPIO_PWM_EN
//   defined   -> a free-running PWM_BITS counter dims the LEDs by CTRL duty
//   undefined -> LEDs follow the LED register directly, CTRL[7:0] reads 0

module board_gpio_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int PWM_BITS        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SW_WIDTH-1:0]  sw_i,
  output logic [LED_WIDTH-1:0] led_o,
  input  logic                 bus_req_i,
  input  logic                 bus_we_i,
  input  logic [3:0]           bus_addr_i,
  input  logic [31:0]          bus_wdata_i,
  output logic                 bus_ack_o,
  output logic [31:0]          bus_rdata_o,
  output logic                 irq_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_SW   = 2'd0,
    REG_LED  = 2'd1,
    REG_EDGE = 2'd2,
    REG_CTRL = 2'd3
  } reg_sel_e;

  logic [SW_WIDTH-1:0]  sync_meta;
  logic [SW_WIDTH-1:0]  sync;
  logic [SW_WIDTH-1:0]  prev;
  logic [SW_WIDTH-1:0]  stable;
  logic [SW_WIDTH-1:0]  stable_d;
  logic [SW_WIDTH-1:0]  stable_next;
  logic [SW_WIDTH-1:0]  edge_flags;
  logic [SW_WIDTH-1:0]  edge_clr;
  logic [CNT_W-1:0]     cnt;
  logic                 tick;

  logic [LED_WIDTH-1:0] led_reg;
  logic                 irq_en;

  reg_sel_e             sel;
  logic                 wr_en;
  logic                 rd_en;
  logic [31:0]          rd_val;

`ifdef BOARD_GPIO_PWM_EN
  logic [7:0]           duty;
  logic [PWM_BITS-1:0]  pwm;
  logic [PWM_BITS-1:0]  duty_p;
  logic                 pwm_on;
`endif

  // Address bits [1:0] and wide write-data bits have no register behind them;
  // folding them here keeps them visibly intentional rather than forgotten.
  logic unused_ok;
  assign unused_ok = ^{bus_addr_i[1:0], bus_wdata_i, (PWM_BITS > 8)};

  // The debounce sample strobe fires on the last count of each sample period.
  // A bit is accepted into stable only when two consecutive samples agree, so
  // anything shorter than one sample period can never be seen twice in a row.
  always_comb begin
    tick        = (cnt == CNT_LAST);
    stable_next = (sync & ~(sync ^ prev)) | (stable & (sync ^ prev));
  end

  // Bus decode and read mux. Reads see the register contents before any
  // write of the same cycle lands, which is what makes EDGE return the
  // pre-clear value.
  always_comb begin
    sel      = reg_sel_e'(bus_addr_i[3:2]);
    wr_en    = bus_req_i & bus_we_i;
    rd_en    = bus_req_i & ~bus_we_i;
    rd_val   = '0;
    edge_clr = '0;
    case (sel)
      REG_SW:   rd_val[SW_WIDTH-1:0]  = stable;
      REG_LED:  rd_val[LED_WIDTH-1:0] = led_reg;
      REG_EDGE: rd_val[SW_WIDTH-1:0]  = edge_flags;
      REG_CTRL: begin
        rd_val[8] = irq_en;
`ifdef BOARD_GPIO_PWM_EN
        rd_val[7:0] = duty;
`endif
      end
      default: rd_val = '0;
    endcase
    if (wr_en && (sel == REG_EDGE)) begin
      edge_clr = bus_wdata_i[SW_WIDTH-1:0];
    end
  end

  // Switch path: two-flop synchronizer, sample prescaler, debounced state and
  // sticky change flags. A change in stable is detected against its delayed
  // copy, so the flag rises the cycle after stable moves. New changes are
  // OR-ed in after the W1C mask so a set always beats a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta  <= '0;
      sync       <= '0;
      prev       <= '0;
      stable     <= '0;
      stable_d   <= '0;
      edge_flags <= '0;
      cnt        <= '0;
    end else begin
      sync_meta <= sw_i;
      sync      <= sync_meta;
      cnt       <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        prev   <= sync;
        stable <= stable_next;
      end
      stable_d   <= stable;
      edge_flags <= (edge_flags & ~edge_clr) | (stable ^ stable_d);
    end
  end

  // Host bus: every sampled request is acknowledged exactly one cycle later,
  // with write side effects landing on that same edge. The interrupt is a
  // registered view of irq_en and the flags as they stood before this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_ack_o   <= 1'b0;
      bus_rdata_o <= '0;
      led_reg     <= '0;
      irq_en      <= 1'b0;
      irq_o       <= 1'b0;
`ifdef BOARD_GPIO_PWM_EN
      duty        <= '0;
`endif
    end else begin
      bus_ack_o   <= bus_req_i;
      bus_rdata_o <= rd_en ? rd_val : '0;
      irq_o       <= irq_en & (|edge_flags);
      if (wr_en) begin
        case (sel)
          REG_LED:  led_reg <= bus_wdata_i[LED_WIDTH-1:0];
          REG_CTRL: begin
            irq_en <= bus_wdata_i[8];
`ifdef BOARD_GPIO_PWM_EN
            duty   <= bus_wdata_i[7:0];
`endif
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BOARD_GPIO_PWM_EN
  // LED dimming: a free-running counter is compared against the low duty bits.
  // An all-ones duty is treated as fully on so the top step is not one short.
  always_comb begin
    duty_p = duty[PWM_BITS-1:0];
    pwm_on = (pwm < duty_p) | (&duty_p);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm   <= '0;
      led_o <= '0;
    end else begin
      pwm   <= pwm + PWM_BITS'(1);
      led_o <= led_reg & {LED_WIDTH{pwm_on}};
    end
  end
`else
  // Without dimming the LEDs simply follow the LED register, one cycle behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_o <= '0;
    end else begin
      led_o <= led_reg;
    end
  end
`endif

endmodule

// File: doc/board_gpio_ctrl.md
BOARD_GPIO_CTRL -- requirements
Module: board_gpio_ctrl

Interface
REQ-001 SHALL have parameter SW_WIDTH, default 16: number of switch inputs (1..32).
REQ-002 SHALL have parameter LED_WIDTH, default 16: number of LED outputs (1..32).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 100000: debounce sample period in clk_i cycles (>=2).
REQ-004 SHALL have parameter PWM_BITS, default 8: LED brightness counter width (1..8).
REQ-005 SHALL have one clock and synchronous active-high reset: clk_i  in  1  sole clock, all logic on rising edge; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have sw_i  in  SW_WIDTH  raw asynchronous board switches.
REQ-007 SHALL have led_o  out  LED_WIDTH  LED drive.
REQ-008 SHALL have bus_req_i  in  1, bus_we_i  in  1, bus_addr_i  in  4, bus_wdata_i  in  32: host request.
REQ-009 SHALL have bus_ack_o  out  1, bus_rdata_o  out  32: host response.
REQ-010 SHALL have irq_o  out  1: switch-change interrupt, level.

Function
REQ-011 SHALL pass sw_i through a 2-flop synchronizer per bit (sync).
REQ-012 SHALL run prescaler cnt 0..DEBOUNCE_CYCLES-1, wrapping to 0; tick = (cnt == DEBOUNCE_CYCLES-1).
REQ-013 On tick SHALL load prev <= sync and, per bit, stable[i] <= sync[i] only if sync[i] == prev[i]; otherwise stable[i] holds.
REQ-014 A switch change held steady SHALL reach stable within 2 ticks + 2 cycles; a glitch shorter than one sample period SHALL never reach stable.
REQ-015 SHALL set edge[i] in the cycle after stable[i] changes (either direction); edge bits sticky.
REQ-016 Register map (bus_addr_i[3:2]): 0 SW (RO, stable, zero-extended); 1 LED (RW, led_reg[LED_WIDTH-1:0]); 2 EDGE (read edge, write-1-to-clear); 3 CTRL (RW, [7:0] duty, [8] irq_en).
REQ-017 Bus: bus_req_i sampled each cycle; bus_ack_o SHALL pulse exactly one cycle later, bus_rdata_o valid only while bus_ack_o=1, else 0; back-to-back requests SHALL each get one ack.
REQ-018 Writes SHALL take effect on the ack cycle; bits above register width ignored, read back as 0.
REQ-019 Simultaneous EDGE W1C and new change on same bit: set SHALL win.
REQ-020 irq_o SHALL equal irq_en & |edge, registered (one cycle after edge/irq_en update).
REQ-021 Read of EDGE and W1C in same access impossible (single we); read returns pre-clear value.

Reset
REQ-022 rst_i high at rising edge SHALL clear sync, prev, stable, edge, cnt, led_reg, CTRL, PWM counter, bus_ack_o, bus_rdata_o, irq_o to 0; led_o=0 next cycle.
REQ-023 Reset mid-debounce or mid-bus-access SHALL abort it: no ack issued for a request sampled in the reset cycle.
REQ-024 Switches high out of reset SHALL produce stable=1 and edge=1 after debounce (power-up change reported).

Configuration
REQ-025 Macro BOARD_GPIO_PWM_EN defined: free-running PWM_BITS counter pwm; led_o[i] = led_reg[i] & ((pwm < duty[PWM_BITS-1:0]) | (duty[PWM_BITS-1:0] all ones)); duty=0 gives off.
REQ-026 BOARD_GPIO_PWM_EN undefined: no PWM counter; led_o = led_reg registered; CTRL[7:0] SHALL read 0, writes ignored.

Verification (bench: SW_WIDTH=16, LED_WIDTH=16, DEBOUNCE_CYCLES=4, PWM_BITS=8)
REQ-027 Reset, sw_i=0x0005 held -> SW reads 0x0005 within 10 cycles; EDGE reads 0x0005; with irq_en=1 irq_o=1; W1C 0x0005 -> EDGE 0, irq_o=0 next cycle.
REQ-028 sw_i bit 3 pulsed high 2 cycles between ticks -> SW and EDGE unchanged after 20 cycles.
REQ-029 Write LED=0xA5A5, CTRL=0x0FF -> led_o=0xA5A5 constantly; read LED returns 0x0000A5A5, ack exactly 1 cycle after req.
REQ-030 PWM_EN defined, LED=0xFFFF, duty=0x40 -> led_o=0xFFFF for exactly 64 of every 256 cycles; undefined -> led_o=0xFFFF always, CTRL reads 0x100 after writing 0x140.
REQ-031 EDGE W1C 0x0008 in the same cycle bit 3 sets -> EDGE bit 3 remains 1.
REQ-032 rst_i asserted with bus_req_i=1 and sw_i changing -> no ack, all outputs 0 next cycle, debounce restarts from cnt=0.
